// File: rtl/caster_csr_pkg.sv
// Shared definitions for the caster CSR SPI link: frame layout constants,
// the master state encoding and small helpers used by both ends of the link.
package caster_csr_pkg;

    localparam int CSR_FRAME_BITS = 16;
    localparam int CSR_RW_BIT     = 15;
    localparam int CSR_ADDR_W     = 7;
    localparam int CSR_DATA_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } csr_spi_state_t;

    // Assemble the 16-bit frame: R/W flag on top (1 = read), address, then
    // write data, which is forced to zero for reads.
    function automatic logic [CSR_FRAME_BITS-1:0] csrBuildFrame(
        input logic                  isWrite,
        input logic [CSR_ADDR_W-1:0] addr,
        input logic [CSR_DATA_W-1:0] wdata
    );
        return {~isWrite, addr, (isWrite ? wdata : {CSR_DATA_W{1'b0}})};
    endfunction

    // Largest of three integers, used to size the shared CS phase counter.
    function automatic int csrMax3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dff_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module dff_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain toward o_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/csr_spi_master.sv
// SPI mode-0 master issuing one 16-bit register frame (R/W, 7-bit address,
// 8-bit data) per chip-select window toward the caster CSR slave. SCK is a
// slow divided clock so the slave can oversample it in its own domain.
module csr_spi_master
    import caster_csr_pkg::*;
#(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [CSR_ADDR_W-1:0] req_addr,
    input  logic [CSR_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [CSR_DATA_W-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  spi_cs,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int CS_MAX = csrMax3(CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int PH_W   = $clog2(CS_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0]  IDLE_LAST  = PH_W'(CS_IDLE - 1);
    localparam logic [3:0]       FIRST_BIT  = 4'(CSR_FRAME_BITS - 1);

    csr_spi_state_t r_state;

    logic [DIV_W-1:0]            r_divCnt;
    logic [PH_W-1:0]             r_phCnt;
    logic [3:0]                  r_bitCnt;
    logic [CSR_FRAME_BITS-2:0]   r_txShift;
    logic [CSR_DATA_W-1:0]       r_rxShift;
    logic                        r_isRead;
    logic                        r_cs;
    logic                        r_sck;
    logic                        r_mosi;
    logic                        r_rspValid;
    logic [CSR_DATA_W-1:0]       r_rspRdata;
    logic                        r_busy;

    logic [CSR_FRAME_BITS-1:0]   w_reqFrame;
    logic                        w_misoSync;

    assign w_reqFrame = csrBuildFrame(req_write, req_addr, req_wdata);

    dff_sync #(
        .STAGES (2)
    ) u_misoSync (
        .clk (clk),
        .rst (rst),
        .i_d (spi_miso),
        .o_q (w_misoSync)
    );

    // Frame sequencer: accepts a request, frames CS around 16 SCK periods,
    // shifts MOSI out and MISO in, then enforces the CS idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_divCnt   <= '0;
            r_phCnt    <= '0;
            r_bitCnt   <= '0;
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_isRead   <= 1'b0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_rspValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_txShift <= w_reqFrame[CSR_FRAME_BITS-2:0];
                        r_mosi    <= w_reqFrame[CSR_RW_BIT];
                        r_isRead  <= ~req_write;
                        r_cs      <= 1'b0;
                        r_sck     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_phCnt   <= '0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_phCnt == SETUP_LAST) begin
                        r_divCnt <= '0;
                        r_bitCnt <= FIRST_BIT;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_phCnt <= r_phCnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_divCnt != DIV_LAST) begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end else begin
                        r_divCnt <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bitCnt < 4'd8) begin
                                r_rxShift <= {r_rxShift[CSR_DATA_W-2:0], w_misoSync};
                            end
                            if (r_bitCnt == 4'd0) begin
                                r_phCnt <= '0;
                                r_state <= ST_HOLD;
                            end else begin
                                r_bitCnt  <= r_bitCnt - 1'b1;
                                r_mosi    <= r_txShift[CSR_FRAME_BITS-2];
                                r_txShift <= {r_txShift[CSR_FRAME_BITS-3:0], 1'b0};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_phCnt == HOLD_LAST) begin
                        r_cs       <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_rspRdata <= r_isRead ? r_rxShift : '0;
                        r_phCnt    <= '0;
                        r_state    <= ST_GAP;
                    end else begin
                        r_phCnt <= r_phCnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_phCnt == IDLE_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_phCnt <= r_phCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign busy      = r_busy;
    assign spi_cs    = r_cs;
    assign spi_sck   = r_sck;
    assign spi_mosi  = r_mosi;

endmodule

// File: tb/tb_csr_spi_master.sv
// Bench for csr_spi_master: instance 0 uses the default timing, instance 1
// the minimum divider and CS timings. A slave model records MOSI and drives
// MISO; a monitor pops expected frames/responses and checks the timeline.
module tb_csr_spi_master;

    typedef struct packed {
        logic [15:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    logic       clk;
    logic       rst       [2];
    logic       reqValid  [2];
    logic       reqReady  [2];
    logic       reqWrite  [2];
    logic [6:0] reqAddr   [2];
    logic [7:0] reqWdata  [2];
    logic       rspValid  [2];
    logic [7:0] rspRdata  [2];
    logic       busy      [2];
    logic       spiCs     [2];
    logic       spiSck    [2];
    logic       spiMosi   [2];
    logic       spiMiso   [2];

    exp_t       expQ      [2][$];
    logic [7:0] slaveQ    [2][$];
    int         accQ      [2][$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        prevSck    [2];
    logic        prevCs     [2];
    logic        aborted    [2];
    logic        firstRise  [2];
    logic        waitReady  [2];
    logic        everFell   [2];
    int          sckRun     [2];
    int          csRun      [2];
    int          bitsSeen   [2];
    int          framesSeen [2];
    int          rspCyc     [2];
    logic [15:0] mosiFrame  [2];
    logic [15:0] slaveShift [2];

    csr_spi_master #(
        .CLK_DIV  (8),
        .CS_SETUP (4),
        .CS_HOLD  (4),
        .CS_IDLE  (4)
    ) dutDefault (
        .clk       (clk),
        .rst       (rst[0]),
        .req_valid (reqValid[0]),
        .req_ready (reqReady[0]),
        .req_write (reqWrite[0]),
        .req_addr  (reqAddr[0]),
        .req_wdata (reqWdata[0]),
        .rsp_valid (rspValid[0]),
        .rsp_rdata (rspRdata[0]),
        .busy      (busy[0]),
        .spi_cs    (spiCs[0]),
        .spi_sck   (spiSck[0]),
        .spi_mosi  (spiMosi[0]),
        .spi_miso  (spiMiso[0])
    );

    csr_spi_master #(
        .CLK_DIV  (2),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .CS_IDLE  (1)
    ) dutMin (
        .clk       (clk),
        .rst       (rst[1]),
        .req_valid (reqValid[1]),
        .req_ready (reqReady[1]),
        .req_write (reqWrite[1]),
        .req_addr  (reqAddr[1]),
        .req_wdata (reqWdata[1]),
        .rsp_valid (rspValid[1]),
        .rsp_rdata (rspRdata[1]),
        .busy      (busy[1]),
        .spi_cs    (spiCs[1]),
        .spi_sck   (spiSck[1]),
        .spi_mosi  (spiMosi[1]),
        .spi_miso  (spiMiso[1])
    );

    // 10 ns clock shared by both instances.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-computed timeline constants: default instance, then minimum one.
    function automatic int rspLat(input int i);
        return (i == 0) ? 265 : 67;
    endfunction
    function automatic int riseLat(input int i);
        return (i == 0) ? 13 : 4;
    endfunction
    function automatic int csLowLen(input int i);
        return (i == 0) ? 264 : 66;
    endfunction
    function automatic int divLen(input int i);
        return (i == 0) ? 8 : 2;
    endfunction
    function automatic int idleLen(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic checkAtLeast(input string name, input int act, input int req);
        checks++;
        if (act < req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required>=%0d", name, act, req);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=event-missing-or-unexpected required=consistent-sequence", name);
    endtask

    // One monitor/slave step for instance i, evaluated mid-cycle.
    task automatic monitorStep(input int i);
        exp_t e;
        logic [7:0] sd;
        if (rst[i] && !spiCs[i]) aborted[i] = 1'b1;
        if (reqValid[i] && reqReady[i] && !rst[i]) accQ[i].push_back(cyc);

        if (spiSck[i] !== prevSck[i]) begin
            if (!aborted[i]) begin
                if (spiSck[i]) begin
                    if (!firstRise[i]) begin
                        if (accQ[i].size() == 0) failNow("firstRiseNoAccept");
                        else checkOutput("firstRiseLatency", cyc - accQ[i][0], riseLat(i));
                    end else begin
                        checkOutput("sckLowPhase", sckRun[i], divLen(i));
                    end
                    firstRise[i] = 1'b1;
                    mosiFrame[i] = {mosiFrame[i][14:0], spiMosi[i]};
                    bitsSeen[i]++;
                end else begin
                    checkOutput("sckHighPhase", sckRun[i], divLen(i));
                    slaveShift[i] = {slaveShift[i][14:0], 1'b0};
                    spiMiso[i] = slaveShift[i][15];
                end
            end
            sckRun[i] = 1;
        end else begin
            sckRun[i]++;
        end

        if (spiCs[i] !== prevCs[i]) begin
            if (!spiCs[i]) begin
                if (everFell[i]) checkAtLeast("csIdleGap", csRun[i], idleLen(i));
                if (accQ[i].size() == 0) failNow("csFallNoAccept");
                else checkOutput("csFallLatency", cyc - accQ[i][0], 1);
                sd = 8'h5A;
                if (slaveQ[i].size() > 0) sd = slaveQ[i].pop_front();
                slaveShift[i] = {8'h00, sd};
                spiMiso[i] = slaveShift[i][15];
                mosiFrame[i] = '0;
                bitsSeen[i] = 0;
                firstRise[i] = 1'b0;
                everFell[i] = 1'b1;
            end else if (aborted[i]) begin
                checkOutput("abortNoRsp", rspValid[i], 0);
                if (accQ[i].size() > 0) void'(accQ[i].pop_front());
                aborted[i] = 1'b0;
            end else begin
                checkOutput("csLowLen", csRun[i], csLowLen(i));
                checkOutput("bitCount", bitsSeen[i], 16);
                checkOutput("rspValidAtCsRise", rspValid[i], 1);
                if (accQ[i].size() == 0) failNow("rspNoAccept");
                else checkOutput("rspLatency", cyc - accQ[i].pop_front(), rspLat(i));
                if (expQ[i].size() == 0) begin
                    failNow("unexpectedFrame");
                end else begin
                    e = expQ[i].pop_front();
                    checkOutput("mosiFrame", mosiFrame[i], e.frame);
                    checkOutput("rspRdata", rspRdata[i], e.rdata);
                end
                framesSeen[i]++;
                rspCyc[i] = cyc;
                waitReady[i] = 1'b1;
            end
            csRun[i] = 1;
        end else begin
            csRun[i]++;
            if (rspValid[i]) failNow("spuriousRsp");
        end

        if (waitReady[i] && reqReady[i]) begin
            checkOutput("readyReturn", cyc - rspCyc[i], idleLen(i));
            waitReady[i] = 1'b0;
        end
        prevSck[i] = spiSck[i];
        prevCs[i]  = spiCs[i];
    endtask

    // Monitor and slave model, sampling on the falling clock edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            prevSck[i] = 1'b0;    prevCs[i] = 1'b1;     aborted[i] = 1'b0;
            firstRise[i] = 1'b0;  waitReady[i] = 1'b0;  everFell[i] = 1'b0;
            sckRun[i] = 0;        csRun[i] = 0;         bitsSeen[i] = 0;
            framesSeen[i] = 0;    rspCyc[i] = 0;
            mosiFrame[i] = '0;    slaveShift[i] = '0;   spiMiso[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) monitorStep(i);
        end
    end

    // Present one request; the expected frame/response enter the scoreboard on
    // the acceptance cycle. With scramble set, junk is shown while not ready.
    task automatic applyStimulus(input int i, input logic wr, input logic [6:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] slaveData,
                                 input logic [15:0] expFrame, input logic [7:0] expRdata,
                                 input bit scramble, input bit keepValid, input bit track);
        bit   accepted;
        exp_t e;
        accepted = 1'b0;
        reqValid[i] = 1'b1;
        if (!scramble) begin
            reqWrite[i] = wr;
            reqAddr[i]  = addr;
            reqWdata[i] = wdata;
        end
        for (int n = 0; n < 3000 && !accepted; n++) begin
            @(negedge clk);
            if (reqReady[i]) begin
                reqWrite[i] = wr;
                reqAddr[i]  = addr;
                reqWdata[i] = wdata;
                if (track) begin
                    e.frame = expFrame;
                    e.rdata = expRdata;
                    expQ[i].push_back(e);
                    slaveQ[i].push_back(slaveData);
                end
                accepted = 1'b1;
            end else if (scramble) begin
                reqWrite[i] = ~wr;
                reqAddr[i]  = addr ^ 7'(n + 1);
                reqWdata[i] = ~wdata;
            end
        end
        if (!accepted) failNow("acceptTimeout");
        @(posedge clk);
        #1;
        if (!keepValid) reqValid[i] = 1'b0;
        if (scramble) reqAddr[i] = ~addr;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy[0] || busy[1]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy[0] || busy[1]) failNow("drainTimeout");
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Directed sequence with hand-computed frames and read data.
    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;      reqValid[i] = 1'b0;  reqWrite[i] = 1'b0;
            reqAddr[i] = '0;    reqWdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("resetCs", spiCs[i], 1);
            checkOutput("resetSck", spiSck[i], 0);
            checkOutput("resetMosi", spiMosi[i], 0);
            checkOutput("resetRspValid", rspValid[i], 0);
            checkOutput("resetRspRdata", rspRdata[i], 0);
            checkOutput("resetBusy", busy[i], 0);
            rst[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) checkOutput("readyAfterReset", reqReady[i], 1);

        $display("[TB] write 0x15 <- 0xA5");
        applyStimulus(0, 1'b1, 7'h15, 8'hA5, 8'hC3, 16'h15A5, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] read 0x7F, slave returns 0x3C");
        applyStimulus(0, 1'b0, 7'h7F, 8'h66, 8'h3C, 16'hFF00, 8'h3C, 1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] three back-to-back requests");
        applyStimulus(0, 1'b1, 7'h22, 8'h5A, 8'h11, 16'h225A, 8'h00, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 7'h40, 8'h00, 8'h99, 16'hC000, 8'h99, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 7'h0F, 8'hF0, 8'h22, 16'h0FF0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] reset during bit 9 of a read");
        applyStimulus(0, 1'b0, 7'h33, 8'h00, 8'h00, 16'hB300, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 2000 && bitsSeen[0] != 7; n++) @(negedge clk);
        if (bitsSeen[0] != 7) failNow("bit9Timeout");
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abortCs", spiCs[0], 1);
        checkOutput("abortSck", spiSck[0], 0);
        checkOutput("abortMosi", spiMosi[0], 0);
        checkOutput("abortBusy", busy[0], 0);
        checkOutput("abortRspValid", rspValid[0], 0);
        rst[0] = 1'b0;
        drain();
        applyStimulus(0, 1'b0, 7'h01, 8'h00, 8'hE7, 16'h8100, 8'hE7, 1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] back-pressure with changing request fields");
        applyStimulus(0, 1'b1, 7'h10, 8'h01, 8'hAA, 16'h1001, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 7'h55, 8'h77, 8'h42, 16'hD500, 8'h42, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 7'h6B, 8'h3E, 8'h00, 16'h6B3E, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();

        $display("[TB] minimum divider instance");
        applyStimulus(1, 1'b0, 7'h2A, 8'h00, 8'h81, 16'hAA00, 8'h81, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 7'h7E, 8'h18, 8'hFF, 16'h7E18, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        checkOutput("framesDefault", framesSeen[0], 9);
        checkOutput("framesMin", framesSeen[1], 2);
        checkOutput("scoreboardEmpty0", expQ[0].size(), 0);
        checkOutput("scoreboardEmpty1", expQ[1].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
